// File: rtl/disp_pkg.sv
// Shared display-select definitions: sequencer state encoding and mux select codes.
// Consumed by both the display sequencer and the six-digit display multiplexer.
package disp_pkg;

  typedef enum logic [2:0] {
    ST_MODE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_PLAY   = 3'd2,
    ST_FLASH  = 3'd3,
    ST_RES_HI = 3'd4,
    ST_RES_LO = 3'd5
  } disp_state_e;

  localparam logic [2:0] SEL_DASH     = 3'b000;
  localparam logic [2:0] SEL_MODE     = 3'b001;
  localparam logic [2:0] SEL_SCRAM    = 3'b010;
  localparam logic [2:0] SEL_SCORE_HI = 3'b011;
  localparam logic [2:0] SEL_SCORE_LO = 3'b100;

  // WAIT and FLASH both show dashes; any unused encoding falls back to dashes too.
  function automatic logic [2:0] sel_of_state(disp_state_e s);
    logic [2:0] sel;
    case (s)
      ST_MODE:   sel = SEL_MODE;
      ST_PLAY:   sel = SEL_SCRAM;
      ST_RES_HI: sel = SEL_SCORE_HI;
      ST_RES_LO: sel = SEL_SCORE_LO;
      default:   sel = SEL_DASH;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/disp_seq_ctrl_if.sv
// Game-flow event inputs and display-select outputs of the display sequencer.
// master = game-flow side, slave = sequencer.
interface disp_seq_ctrl_if;
  logic       tick;
  logic       start;
  logic       round_new;
  logic       round_done;
  logic       game_over;
  logic       ack;
  logic [2:0] controlSig;
  logic [2:0] state_o;
  logic       pend_o;

  modport master (
    output tick, start, round_new, round_done, game_over, ack,
    input  controlSig, state_o, pend_o
  );

  modport slave (
    input  tick, start, round_new, round_done, game_over, ack,
    output controlSig, state_o, pend_o
  );
endinterface

// File: rtl/disp_tick_timer.sv
// Counts prescaler ticks up to limit; done flags the tick that completes the count.
// The counter clears itself on done and whenever the owner asserts clr.
module disp_tick_timer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = tick && (cnt_q == limit - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || done) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_seq_ctrl.sv
// Display sequencer: walks mode/wait/play/flash/results pages from game events and
// drives the display-mux select code straight from the state register.
module disp_seq_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned PAGE_TICKS  = 3000,
  parameter int unsigned FLASH_TICKS = 500,
  parameter int unsigned CNT_W       = 12
) (
  input  logic           clk,
  input  logic           rst,
  disp_seq_ctrl_if.slave bus
);

  disp_state_e      state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] limit;
  logic             timer_clr;
  logic             timer_done;

  assign limit = (state_q == ST_FLASH) ? CNT_W'(FLASH_TICKS) : CNT_W'(PAGE_TICKS);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      ST_MODE: begin
        if (bus.start) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.round_new) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.round_done) state_d = bus.game_over ? ST_RES_HI : ST_FLASH;
      end
      ST_FLASH: begin
        if (bus.round_new) pend_d = 1'b1;
        // A round_new arriving on the final tick still counts for this exit.
        if (timer_done) begin
          pend_d = 1'b0;
          if (bus.game_over) begin
            state_d = ST_RES_HI;
          end else if (pend_q || bus.round_new) begin
            state_d = ST_PLAY;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_RES_HI, ST_RES_LO: begin
        if (bus.ack) begin
          state_d = ST_MODE;
        end else if (timer_done) begin
          state_d = (state_q == ST_RES_HI) ? ST_RES_LO : ST_RES_HI;
        end
      end
      default: state_d = ST_MODE;
    endcase
    if (state_d == ST_MODE) pend_d = 1'b0;
  end

  // Counter only runs in the timed states and restarts on every state change.
  assign timer_clr = (state_d != state_q) ||
                     !(state_q inside {ST_FLASH, ST_RES_HI, ST_RES_LO});

  disp_tick_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .tick  (bus.tick),
    .limit (limit),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_MODE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.controlSig = sel_of_state(state_q);
  assign bus.state_o    = state_q;
  assign bus.pend_o     = pend_q;

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Directed vector table plus a long random run against a small behavioural model.
module tb_disp_seq_ctrl;

  localparam int PG = 4;
  localparam int FL = 2;

  typedef struct {
    logic rst;
    logic tick;
    logic start;
    logic rn;
    logic rd;
    logic go;
    logic ack;
    int   exp_st;
    logic exp_pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  disp_seq_ctrl_if bus_if ();

  disp_seq_ctrl #(
    .PAGE_TICKS  (PG),
    .FLASH_TICKS (FL),
    .CNT_W       (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sel_tab[6] = '{1, 0, 2, 0, 3, 4};

  // Tick is asserted on every third vector (indices 1, 4, 7, ...).
  task automatic add(input logic r, input logic s, input logic rn, input logic rd,
                     input logic go, input logic ak, input int st, input logic pd);
    vec_t v;
    v.rst = r; v.start = s; v.rn = rn; v.rd = rd; v.go = go; v.ack = ak;
    v.tick = ((vecs.size() % 3) == 1);
    v.exp_st = st; v.exp_pend = pd;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input int st, input logic pd);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, 0, 0, st, pd);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic tk, input logic s, input logic rn,
                       input logic rd, input logic go, input logic ak);
    rst = r; bus_if.tick = tk; bus_if.start = s; bus_if.round_new = rn;
    bus_if.round_done = rd; bus_if.game_over = go; bus_if.ack = ak;
  endtask

  int   m_st, m_cnt;
  logic m_pend;
  logic r_rst, r_tk, r_s, r_rn, r_rd, r_go, r_ak;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    //  rst s rn rd go ak  state pend
    add(1, 0, 0, 0, 0, 0, 0, 0);            // 0
    add(1, 0, 0, 0, 0, 0, 0, 0);            // 1
    add(0, 0, 0, 0, 0, 0, 0, 0);            // 2
    add(0, 1, 1, 0, 0, 0, 1, 0);            // 3 start+round_new: only start acts
    idle(1, 1, 0);                          // 4
    add(0, 0, 1, 0, 0, 0, 2, 0);            // 5
    add(0, 1, 0, 0, 0, 1, 2, 0);            // 6 start/ack ignored in PLAY
    add(0, 0, 0, 0, 1, 0, 2, 0);            // 7 game_over alone stays in PLAY
    add(0, 0, 0, 1, 0, 0, 3, 0);            // 8 -> FLASH
    idle(4, 3, 0);                          // 9..12, tick at 10
    idle(1, 1, 0);                          // 13 second tick -> WAIT
    add(0, 1, 0, 1, 0, 1, 1, 0);            // 14 wrong-state pulses in WAIT
    add(0, 0, 1, 0, 0, 0, 2, 0);            // 15
    add(0, 0, 0, 1, 0, 0, 3, 0);            // 16 -> FLASH on a tick cycle
    idle(3, 3, 0);                          // 17..19
    add(0, 0, 1, 0, 0, 0, 3, 1);            // 20 round_new latched
    idle(1, 3, 1);                          // 21
    idle(1, 2, 0);                          // 22 exit straight to PLAY
    add(0, 0, 0, 1, 0, 0, 3, 0);            // 23
    idle(4, 3, 0);                          // 24..27
    add(0, 0, 1, 0, 0, 0, 2, 0);            // 28 round_new on final tick
    add(0, 0, 0, 1, 1, 0, 4, 0);            // 29 -> RES_HI
    idle(2, 4, 0);                          // 30..31
    add(0, 0, 1, 0, 0, 0, 4, 0);            // 32 round_new dropped
    add(0, 1, 0, 0, 0, 0, 4, 0);            // 33 start ignored
    idle(6, 4, 0);                          // 34..39
    idle(1, 5, 0);                          // 40 page flip -> RES_LO
    add(0, 0, 1, 0, 0, 0, 5, 0);            // 41
    idle(10, 5, 0);                         // 42..51
    idle(1, 4, 0);                          // 52 back to RES_HI
    idle(11, 4, 0);                         // 53..63
    add(0, 0, 0, 0, 0, 1, 0, 0);            // 64 ack on timeout tick wins
    add(0, 0, 0, 1, 0, 0, 0, 0);            // 65
    add(0, 0, 0, 0, 0, 1, 0, 0);            // 66
    add(0, 1, 0, 0, 0, 0, 1, 0);            // 67
    add(0, 0, 1, 0, 0, 0, 2, 0);            // 68
    idle(1, 2, 0);                          // 69
    add(0, 0, 0, 1, 1, 0, 4, 0);            // 70
    idle(1, 4, 0);                          // 71
    add(0, 0, 0, 0, 0, 1, 0, 0);            // 72 plain ack
    add(0, 1, 0, 0, 0, 0, 1, 0);            // 73
    add(0, 0, 1, 0, 0, 0, 2, 0);            // 74
    idle(1, 2, 0);                          // 75
    add(0, 0, 0, 1, 0, 0, 3, 0);            // 76
    add(0, 0, 1, 0, 0, 0, 3, 1);            // 77
    idle(2, 3, 1);                          // 78..79 (mid-count)
    add(1, 1, 0, 0, 0, 0, 0, 0);            // 80 reset in FLASH beats start
    idle(1, 0, 0);                          // 81
    add(0, 1, 0, 0, 0, 0, 1, 0);            // 82
    add(0, 0, 1, 0, 0, 0, 2, 0);            // 83
    idle(1, 2, 0);                          // 84
    add(0, 0, 0, 1, 1, 0, 4, 0);            // 85
    idle(11, 4, 0);                         // 86..96
    idle(1, 5, 0);                          // 97
    idle(1, 5, 0);                          // 98
    add(1, 1, 0, 0, 0, 1, 0, 0);            // 99 reset in RES_LO
    add(0, 1, 0, 0, 0, 0, 1, 0);            // 100 clean restart

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].tick, vecs[i].start, vecs[i].rn,
            vecs[i].rd, vecs[i].go, vecs[i].ack);
      @(posedge clk);
      #1;
      $display("vec %0d: sel=%0d state=%0d pend=%0d", i,
               bus_if.controlSig, bus_if.state_o, bus_if.pend_o);
      chk($sformatf("v%0d controlSig", i), int'(bus_if.controlSig), sel_tab[vecs[i].exp_st]);
      chk($sformatf("v%0d state_o", i), int'(bus_if.state_o), vecs[i].exp_st);
      chk($sformatf("v%0d pend_o", i), int'(bus_if.pend_o), int'(vecs[i].exp_pend));
    end

    // Random run against a behavioural model.
    m_st = 0; m_cnt = 0; m_pend = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      r_rst = (c < 2) || ($urandom_range(0, 499) == 0);
      r_tk  = ((c % 3) == 1);
      r_s   = ($urandom_range(0, 7) == 0);
      r_rn  = ($urandom_range(0, 7) == 0);
      r_rd  = ($urandom_range(0, 9) == 0);
      r_go  = ($urandom_range(0, 3) == 0);
      r_ak  = ($urandom_range(0, 29) == 0);
      drive(r_rst, r_tk, r_s, r_rn, r_rd, r_go, r_ak);
      if (r_rst) begin
        m_st = 0; m_cnt = 0; m_pend = 1'b0;
      end else begin
        case (m_st)
          0: if (r_s) m_st = 1;
          1: if (r_rn) m_st = 2;
          2: if (r_rd) m_st = r_go ? 4 : 3;
          3: begin
            if (r_rn) m_pend = 1'b1;
            if (r_tk) begin
              if (m_cnt == FL - 1) begin
                m_st = r_go ? 4 : (m_pend ? 2 : 1);
                m_pend = 1'b0;
                m_cnt = 0;
              end else begin
                m_cnt++;
              end
            end
          end
          default: begin
            if (r_ak) begin
              m_st = 0; m_cnt = 0;
            end else if (r_tk) begin
              if (m_cnt == PG - 1) begin
                m_st = 9 - m_st; m_cnt = 0;
              end else begin
                m_cnt++;
              end
            end
          end
        endcase
      end
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d controlSig", c), int'(bus_if.controlSig), sel_tab[m_st]);
      chk($sformatf("rnd%0d state_o", c), int'(bus_if.state_o), m_st);
      chk($sformatf("rnd%0d pend_o", c), int'(bus_if.pend_o), int'(m_pend));
      chk($sformatf("rnd%0d sel_legal", c), int'(bus_if.controlSig <= 3'd4), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
